// File: rtl/fifo_rst_seq_pkg.sv
// Shared definitions for the FIFO reset sequencer.
// State encoding, default parameter values, counter saturation helper.
package fifo_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RESET = 3'd2,
        ST_PAUSE = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    localparam int DEF_NCH       = 4;
    localparam int DEF_CLR_CYC   = 6;
    localparam int DEF_RST_CYC   = 11;
    localparam int DEF_PAUSE_CYC = 16;
    localparam int DEF_CNT_W     = 5;

    // Largest value a hold counter of width w can reach before it sticks.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
// err flags any copy that disagrees with the voted word.
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y,
    output logic         err
);

    assign y   = (a & b) | (a & c) | (b & c);
    assign err = (a != y) || (b != y) || (c != y);

endmodule

// File: rtl/fifo_rst_seq.sv
// FIFO reset sequencer: IDLE -> CLEAR -> RESET -> PAUSE -> RUN.
// Define FIFO_RST_SEQ_TMR_EN to triplicate all state with majority voting.
module fifo_rst_seq
    import fifo_rst_seq_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int CLR_CYC   = DEF_CLR_CYC,
    parameter int RST_CYC   = DEF_RST_CYC,
    parameter int PAUSE_CYC = DEF_PAUSE_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           RESTART,
    input  logic [NCH-1:0] CH_EN,
    output logic [NCH-1:0] FIFO_RST,
    output logic           DONE,
    output logic           BUSY,
    output logic           SEU_ERR
);

    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);

    // Current (voted) register values.
    state_t           st_v;
    logic [CNT_W-1:0] cnt_v;
    logic [NCH-1:0]   msk_v;

    // Next register values.
    state_t           st_n;
    logic [CNT_W-1:0] cnt_n;
    logic [NCH-1:0]   msk_n;
    logic [NCH-1:0]   frst_n;
    logic             done_n;
    logic             busy_n;
    logic             restart_hit;

    // Next state, hold counter, mask latch and output decode.
    always_comb begin
        st_n        = st_v;
        cnt_n       = (cnt_v == CNT_SAT) ? cnt_v : cnt_v + 1'b1;
        msk_n       = msk_v;
        frst_n      = '0;
        done_n      = 1'b0;
        busy_n      = 1'b1;
        restart_hit = RESTART &&
                      (st_v inside {ST_CLEAR, ST_RESET, ST_PAUSE, ST_RUN});

        case (st_v)
            ST_IDLE:  st_n = ST_CLEAR;
            ST_CLEAR: if (cnt_v == CLR_LAST) st_n = ST_RESET;
            ST_RESET: if (cnt_v == RST_LAST) st_n = ST_PAUSE;
            ST_PAUSE: if (cnt_v == PAUSE_LAST) st_n = ST_RUN;
            ST_RUN:   st_n = ST_RUN;
            default:  st_n = ST_IDLE;
        endcase

        if (restart_hit) st_n = ST_CLEAR;

        if (st_n != st_v || restart_hit) cnt_n = '0;

        if (st_n == ST_CLEAR && (st_v != ST_CLEAR || restart_hit))
            msk_n = CH_EN;

        case (st_n)
            ST_IDLE:  frst_n = '1;
            ST_RESET: frst_n = msk_n;
            ST_RUN: begin
                done_n = 1'b1;
                busy_n = 1'b0;
            end
            default:  frst_n = '0;
        endcase
    end

`ifdef FIFO_RST_SEQ_TMR_EN

    state_t           st_q  [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [NCH-1:0]   msk_q [3];
    logic [NCH+1:0]   out_q [3];
    logic [NCH+1:0]   out_v;
    logic [2:0]       st_vr;
    logic [3:0]       err;
    logic             seu_q;

    // Three copies, each loaded from next values derived from the vote.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
                msk_q[i] <= '0;
                out_q[i] <= {{NCH{1'b1}}, 1'b0, 1'b1};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= st_n;
                cnt_q[i] <= cnt_n;
                msk_q[i] <= msk_n;
                out_q[i] <= {frst_n, done_n, busy_n};
            end
        end
    end

    tmr_vote #(.W(3)) u_vote_st (
        .a(st_q[0]), .b(st_q[1]), .c(st_q[2]),
        .y(st_vr), .err(err[0])
    );

    tmr_vote #(.W(CNT_W)) u_vote_cnt (
        .a(cnt_q[0]), .b(cnt_q[1]), .c(cnt_q[2]),
        .y(cnt_v), .err(err[1])
    );

    tmr_vote #(.W(NCH)) u_vote_msk (
        .a(msk_q[0]), .b(msk_q[1]), .c(msk_q[2]),
        .y(msk_v), .err(err[2])
    );

    tmr_vote #(.W(NCH + 2)) u_vote_out (
        .a(out_q[0]), .b(out_q[1]), .c(out_q[2]),
        .y(out_v), .err(err[3])
    );

    assign st_v = state_t'(st_vr);

    // One-cycle flag for a copy that was outvoted (and is now repaired).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) seu_q <= 1'b0;
        else        seu_q <= |err;
    end

    assign {FIFO_RST, DONE, BUSY} = out_v;
    assign SEU_ERR = seu_q;

`else

    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NCH-1:0]   msk_q;
    logic [NCH-1:0]   frst_q;
    logic             done_q;
    logic             busy_q;

    // Single register copy of state, counter, mask and outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            msk_q  <= '0;
            frst_q <= '1;
            done_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            st_q   <= st_n;
            cnt_q  <= cnt_n;
            msk_q  <= msk_n;
            frst_q <= frst_n;
            done_q <= done_n;
            busy_q <= busy_n;
        end
    end

    assign st_v     = st_q;
    assign cnt_v    = cnt_q;
    assign msk_v    = msk_q;
    assign FIFO_RST = frst_q;
    assign DONE     = done_q;
    assign BUSY     = busy_q;
    assign SEU_ERR  = 1'b0;

`endif

endmodule

// File: tb/tb_fifo_rst_seq.sv
// Bench for fifo_rst_seq: sequence-position model plus literal timing pins.
// Random restart, mask and async reset traffic checked every cycle.
module tb_fifo_rst_seq;

    localparam int NCH = 4;
    localparam int CLR = 6;
    localparam int RST = 11;
    localparam int PAU = 16;
    localparam int TOT = CLR + RST + PAU;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           RESTART = 1'b0;
    logic [NCH-1:0] CH_EN = '1;
    logic [NCH-1:0] FIFO_RST;
    logic           DONE;
    logic           BUSY;
    logic           SEU_ERR;

    int checks = 0;
    int errors = 0;
    int edge_n;
    int m_pos;
    logic [NCH-1:0] m_mask;
    logic seu_skip = 1'b0;

    fifo_rst_seq #(
        .NCH(NCH), .CLR_CYC(CLR), .RST_CYC(RST),
        .PAUSE_CYC(PAU), .CNT_W(5)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RESTART(RESTART), .CH_EN(CH_EN),
        .FIFO_RST(FIFO_RST), .DONE(DONE), .BUSY(BUSY), .SEU_ERR(SEU_ERR)
    );

    always #5 CLK = ~CLK;

    // Edges since reset release (edge 1 = first edge with RST_N high).
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Model: position in the sequence, 0 = not started, TOT+1 = running.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pos <= 0;
        end else if (m_pos == 0 || RESTART) begin
            m_pos  <= 1;
            m_mask <= CH_EN;
        end else if (m_pos <= TOT) begin
            m_pos <= m_pos + 1;
        end
    end

    function automatic logic [NCH-1:0] e_frst(int p, logic [NCH-1:0] mk);
        if (p == 0) return '1;
        if (p > CLR && p <= CLR + RST) return mk;
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, got, exp);
        end
    endtask

    // Compare DUT against the model every cycle.
    always @(negedge CLK) begin
        chk("m_fifo_rst", 32'(FIFO_RST), 32'(e_frst(m_pos, m_mask)));
        chk("m_done", 32'(DONE), 32'(m_pos > TOT));
        chk("m_busy", 32'(BUSY), 32'(m_pos <= TOT));
        if (!seu_skip) chk("m_seu", 32'(SEU_ERR), 32'd0);
    end

    task automatic at_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 1000) begin
            @(negedge CLK);
            #2;
            guard++;
        end
        if (edge_n != n) begin
            checks++;
            errors++;
            $display("FAIL edge_sync: got %0d expected %0d", edge_n, n);
        end
    endtask

    task automatic do_reset(input logic [NCH-1:0] mk);
        #1;
        RST_N = 1'b0;
        CH_EN = '0;
        RESTART = 1'b0;
        #1;
        chk("rst_fifo_rst", 32'(FIFO_RST), 32'hF);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd1);
        chk("rst_seu", 32'(SEU_ERR), 32'd0);
        repeat (3) @(negedge CLK);
        #2;
        CH_EN = mk;
        RST_N = 1'b1;
    endtask

    task automatic default_timing(input logic [NCH-1:0] mk);
        at_edge(6);
        chk("t_e6_frst", 32'(FIFO_RST), 32'h0);
        at_edge(7);
        chk("t_e7_frst", 32'(FIFO_RST), 32'(mk));
        at_edge(17);
        chk("t_e17_frst", 32'(FIFO_RST), 32'(mk));
        at_edge(18);
        chk("t_e18_frst", 32'(FIFO_RST), 32'h0);
        at_edge(33);
        chk("t_e33_done", 32'(DONE), 32'd0);
        chk("t_e33_busy", 32'(BUSY), 32'd1);
        at_edge(34);
        chk("t_e34_done", 32'(DONE), 32'd1);
        chk("t_e34_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int hold;
        @(negedge CLK);
        #2;

        // Power-up sequence with all channels enabled.
        do_reset(4'b1111);
        default_timing(4'b1111);

        // Mask latched at CLEAR entry, later changes ignored.
        do_reset(4'b0101);
        at_edge(10);
        CH_EN = 4'b1010;
        at_edge(12);
        chk("mask_e12", 32'(FIFO_RST), 32'h5);
        at_edge(17);
        chk("mask_e17", 32'(FIFO_RST), 32'h5);

        // Restart pulse from RUN.
        at_edge(40);
        RESTART = 1'b1;
        at_edge(41);
        RESTART = 1'b0;
        chk("rr_done", 32'(DONE), 32'd0);
        chk("rr_busy", 32'(BUSY), 32'd1);
        chk("rr_frst", 32'(FIFO_RST), 32'h0);
        at_edge(47);
        chk("rr_mask", 32'(FIFO_RST), 32'hA);
        at_edge(73);
        chk("rr_e73_done", 32'(DONE), 32'd0);
        at_edge(74);
        chk("rr_e74_done", 32'(DONE), 32'd1);

        // Restart from RESET.
        do_reset(4'b1111);
        at_edge(12);
        RESTART = 1'b1;
        at_edge(13);
        RESTART = 1'b0;
        chk("rs_e13_frst", 32'(FIFO_RST), 32'h0);
        at_edge(18);
        chk("rs_e18_frst", 32'(FIFO_RST), 32'h0);
        at_edge(19);
        chk("rs_e19_frst", 32'(FIFO_RST), 32'hF);
        at_edge(45);
        chk("rs_e45_done", 32'(DONE), 32'd0);
        at_edge(46);
        chk("rs_e46_done", 32'(DONE), 32'd1);

        // Async abort in PAUSE and in RUN, then full rerun.
        do_reset(4'b0011);
        at_edge(20);
        chk("ab_pause_frst", 32'(FIFO_RST), 32'h0);
        do_reset(4'b1111);
        at_edge(36);
        chk("ab_run_done", 32'(DONE), 32'd1);
        do_reset(4'b1001);
        default_timing(4'b1001);

        // Restart held high never reaches RUN.
        do_reset(4'b1111);
        RESTART = 1'b1;
        at_edge(80);
        chk("hold_done", 32'(DONE), 32'd0);
        chk("hold_frst", 32'(FIFO_RST), 32'h0);
        RESTART = 1'b0;
        at_edge(112);
        chk("hold_e112_done", 32'(DONE), 32'd0);
        at_edge(113);
        chk("hold_e113_done", 32'(DONE), 32'd1);

`ifdef FIFO_RST_SEQ_TMR_EN
        // Upset one state copy during PAUSE.
        do_reset(4'b1111);
        at_edge(20);
        seu_skip = 1'b1;
        force dut.st_q[2] = fifo_rst_seq_pkg::ST_RUN;
        #1;
        release dut.st_q[2];
        at_edge(21);
        chk("tmr_seu_hi", 32'(SEU_ERR), 32'd1);
        at_edge(22);
        chk("tmr_seu_lo", 32'(SEU_ERR), 32'd0);
        seu_skip = 1'b0;
        at_edge(33);
        chk("tmr_e33_done", 32'(DONE), 32'd0);
        at_edge(34);
        chk("tmr_e34_done", 32'(DONE), 32'd1);
`endif

        // Random traffic.
        do_reset(4'($urandom));
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #2;
            if (hold > 0) begin
                hold--;
                if (hold == 0) RST_N = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                RST_N = 1'b0;
                hold = $urandom_range(1, 3);
            end
            RESTART = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) CH_EN = 4'($urandom);
        end
        RST_N = 1'b1;
        RESTART = 1'b0;
        repeat (40) @(negedge CLK);
        #2;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rst_seq.md
FIFO_RST_SEQ -- requirements
Module: fifo_rst_seq

Interface
REQ-001 Parameter NCH, default 4: number of FIFO channels sequenced, range 1..16.
REQ-002 Parameter CLR_CYC, default 6: cycles spent in CLEAR, range 1..2**CNT_W-1.
REQ-003 Parameter RST_CYC, default 11: cycles FIFO_RST is asserted in RESET, range 1..2**CNT_W-1.
REQ-004 Parameter PAUSE_CYC, default 16: cycles spent in PAUSE, range 1..2**CNT_W-1.
REQ-005 Parameter CNT_W, default 5: hold counter width in bits.
REQ-006 CLK  input  1  single clock; all logic on its rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 RESTART  input  1  synchronous request to re-run the reset sequence.
REQ-009 CH_EN  input  NCH  per-channel enable mask applied to FIFO_RST.
REQ-010 FIFO_RST  output  NCH  per-channel FIFO reset, registered.
REQ-011 DONE  output  1  sequence complete, FIFOs usable, registered.
REQ-012 BUSY  output  1  sequence in progress (any state except RUN), registered.
REQ-013 SEU_ERR  output  1  one-cycle pulse when any replicated register copy disagrees with the vote.

Function
REQ-014 States IDLE, CLEAR, RESET, PAUSE, RUN; all outputs decoded from next state and registered.
REQ-015 IDLE -> CLEAR unconditionally on the first CLK edge after RST_N deasserts.
REQ-016 CLEAR: FIFO_RST all 0 for CLR_CYC cycles, then -> RESET.
REQ-017 RESET: FIFO_RST = latched mask for RST_CYC cycles, then -> PAUSE.
REQ-018 PAUSE: FIFO_RST all 0 for PAUSE_CYC cycles, then -> RUN.
REQ-019 RUN: DONE=1, BUSY=0, FIFO_RST=0; state held until RESTART or reset.
REQ-020 Counting edges from the first rising edge with RST_N high as edge 1:
- FIFO_RST equals the mask after edges CLR_CYC+1 through CLR_CYC+RST_CYC.
- DONE rises after edge CLR_CYC+RST_CYC+PAUSE_CYC+1; with defaults this is edges 7..17 and edge 34.
REQ-021 CH_EN is latched on every entry to CLEAR; changes during the sequence have no effect until the next entry.
REQ-022 RESTART=1 in any of CLEAR, RESET, PAUSE or RUN sends the FSM to CLEAR on the next edge with the counter cleared:
- DONE drops and BUSY rises on that same edge.
- RESTART in IDLE is ignored.
REQ-023 RESTART held high keeps the FSM in CLEAR with the counter at 0; RUN is never reached.
REQ-024 The hold counter clears on every state change and saturates at 2**CNT_W-1; it never wraps.
REQ-025 An unused state encoding goes to IDLE on the next edge, restarting the full sequence.

Reset
REQ-026 While RST_N is low, the block holds:
- FIFO_RST all 1, irrespective of CH_EN.
- DONE=0, BUSY=1, SEU_ERR=0.
- State IDLE, counter 0.
REQ-027 Reset asserted mid-sequence aborts it asynchronously; after release the full sequence restarts per REQ-020.

Configuration
REQ-028 FIFO_RST_SEQ_TMR_EN defined:
- State, counter, mask and output registers are triplicated.
- Each copy computes next values from the majority-voted state.
- Outputs are the majority vote of the three copies.
- SEU_ERR pulses for one cycle whenever any copy differs from the vote.
- A single corrupted copy is corrected within one cycle.
REQ-029 FIFO_RST_SEQ_TMR_EN undefined: single register copy, SEU_ERR tied 0; cycle behaviour otherwise identical.

Structure
REQ-030 Package fifo_rst_seq_pkg holds:
- State encoding constants.
- Default parameter values.
- Counter saturation constant function.
REQ-031 Sub-module tmr_vote: parameterised-width bitwise majority voter with mismatch flag, instantiated per voted register group only when TMR is enabled.

Verification
REQ-032 Defaults, CH_EN=4'b1111, release RST_N -> FIFO_RST=4'hF after edges 7..17 only; DONE=1 from edge 34; BUSY=0 from edge 34.
REQ-033 CH_EN=4'b0101 at CLEAR entry, changed to 4'b1010 at edge 10 -> FIFO_RST=4'b0101 throughout RESET.
REQ-034 RESTART one-cycle pulse at edge 40 (RUN) -> DONE=0 after edge 41; second DONE at edge 41+33.
REQ-035 RESTART at edge 12 (RESET) -> FIFO_RST=0 after edge 13; RESET re-entered after edge 13+6; DONE after edge 13+33.
REQ-036 RST_N low at edge 20 -> FIFO_RST=4'hF, DONE=0 immediately (asynchronous); after release, REQ-032 timing repeats.
REQ-037 TMR build: force state copy 2 to RUN during PAUSE -> SEU_ERR pulses once; outputs unaffected; DONE still at edge 34.
